// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter: shares one SDRAM request port between a streaming
// pixel writer (addresses generated here) and a random-access display reader.
// Reads win by fixed priority; a starvation counter forces a write grant once
// the writer has lost STARVE_LIMIT consecutive arbitration rounds.
//
// Handshake semantics (all interfaces): a transfer happens on a rising clock
// edge where valid and ready are both 1. Requesters hold valid and payload
// until accepted; wr_ready/rd_ready may only be 1 in IDLE and are never
// asserted while a memory request is outstanding. mem_valid, once raised,
// stays high with mem_we/mem_addr/mem_wdata unchanged until mem_ready.
module sdram_frame_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = 307200,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  input  logic              wr_sof,
  output logic              wr_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [7:0]        rd_data,
  output logic              rd_data_valid,
  output logic              frame_done,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rdata_valid,
  output logic [1:0]        dbg_state
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_PIXELS - 1);
  // Address following a start-of-frame pixel; a one-pixel frame wraps to 0.
  localparam logic [ADDR_W-1:0] SOF_NEXT   = (FRAME_PIXELS > 1) ? ADDR_W'(1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [7:0]          req_data_q, req_data_d;
  logic                frame_done_q;
  logic [7:0]          rd_data_q;
  logic                rd_dv_q;

  logic                in_idle;
  logic                rd_grant;
  logic                wr_grant;

  // Grant selection: only in IDLE and never while reset is asserted.
  always_comb begin
    in_idle  = (state_q == S_IDLE);
    rd_grant = reset & in_idle & rd_valid & (~wr_valid | (starve_q < STARVE_MAX));
    wr_grant = reset & in_idle & wr_valid & ~rd_grant;
  end

  // Next-state, request latch, write pointer and starvation counter.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    wr_addr_d  = wr_addr_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    case (state_q)
      S_IDLE: begin
        if (rd_grant) begin
          state_d    = S_RD;
          req_addr_d = rd_addr;
          req_data_d = '0;
          if (wr_valid) begin
            starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end else if (wr_grant) begin
          state_d    = S_WR;
          req_data_d = wr_data;
          starve_d   = '0;
          if (wr_sof) begin
            req_addr_d = '0;
            wr_addr_d  = SOF_NEXT;
          end else begin
            req_addr_d = wr_addr_q;
            wr_addr_d  = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
          end
        end else begin
          starve_d = '0;
        end
      end
      S_RD, S_WR: begin
        if (mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Arbiter state and latched request; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      wr_addr_q  <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      wr_addr_q  <= wr_addr_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
    end
  end

  // End-of-frame pulse and read-return pipeline stage (state independent).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done_q <= 1'b0;
      rd_data_q    <= '0;
      rd_dv_q      <= 1'b0;
    end else begin
      frame_done_q <= (state_q == S_WR) & mem_ready & (req_addr_q == LAST_ADDR);
      rd_data_q    <= mem_rdata;
      rd_dv_q      <= mem_rdata_valid;
    end
  end

  // Output mapping; write data is forced to 0 on reads.
  always_comb begin
    wr_ready      = wr_grant;
    rd_ready      = rd_grant;
    mem_valid     = (state_q != S_IDLE);
    mem_we        = (state_q == S_WR);
    mem_addr      = req_addr_q;
    mem_wdata     = mem_we ? req_data_q : 8'h00;
    frame_done    = frame_done_q;
    rd_data       = rd_data_q;
    rd_data_valid = rd_dv_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Testbench for sdram_frame_arbiter with a small frame (8 pixels) and a
// starvation limit of 4. A transaction-level model predicts grants, the
// outstanding memory request, write addresses, frame_done and read return;
// directed sections pin concrete addresses, data and grant order.
module tb_sdram_frame_arbiter;

  localparam int AW = 19;
  localparam int FP = 8;
  localparam int SL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          wr_valid, wr_sof, wr_ready;
  logic [7:0]    wr_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rd_data_valid, frame_done;
  logic          mem_valid, mem_we, mem_ready, mem_rdata_valid;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  sdram_frame_arbiter #(.ADDR_W(AW), .FRAME_PIXELS(FP), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_sof(wr_sof), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .frame_done(frame_done),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Observed memory transfers and frame_done pulses.
  logic [31:0] exp_q[$];
  bit          log_we[$];
  int          log_addr[$];
  int          log_data[$];
  int          log_cyc[$];
  int          fd_cyc[$];

  task automatic clear_logs();
    log_we.delete(); log_addr.delete(); log_data.delete();
    log_cyc.delete(); fd_cyc.delete(); exp_q.delete();
  endtask

  // ---------------- behavioural model ----------------
  // One outstanding request at most; the model just remembers it.
  bit            m_busy;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata;
  int            m_starve;
  int            m_wptr;
  bit            m_fd;
  logic [7:0]    m_prev_rd;
  bit            m_prev_rdv;

  // Compare process: outputs are checked at the falling edge, then the model
  // advances to what the next rising edge must produce.
  always @(negedge clk) begin : compare
    bit rg, wg;
    cyc++;
    if (!reset) begin
      chk("rst_ctl", {wr_ready, rd_ready, rd_data_valid, frame_done, mem_valid, mem_we, dbg_state}, 0);
      chk("rst_data", {rd_data, mem_wdata}, 0);
      chk("rst_addr", mem_addr, 0);
      m_busy = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_starve = 0; m_wptr = 0; m_fd = 0;
      m_prev_rd = '0; m_prev_rdv = 0;
    end else begin
      rg = !m_busy && rd_valid && (!wr_valid || m_starve < SL);
      wg = !m_busy && wr_valid && !rg;
      chk("mem_valid", mem_valid, m_busy);
      if (m_busy) begin
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_we ? m_wdata : 8'h00);
      end
      if (!mem_we) chk("wdata_zero_on_read", mem_wdata, 0);
      chk("rd_ready", rd_ready, rg);
      chk("wr_ready", wr_ready, wg);
      chk("rd_data", rd_data, m_prev_rd);
      chk("rd_data_valid", rd_data_valid, m_prev_rdv);
      chk("frame_done", frame_done, m_fd);

      if (mem_valid && mem_ready) begin
        log_we.push_back(mem_we);
        log_addr.push_back(int'(mem_addr));
        log_data.push_back(int'(mem_wdata));
        log_cyc.push_back(cyc);
      end
      if (frame_done) fd_cyc.push_back(cyc);

      // Advance model across the coming rising edge.
      m_fd = 0;
      if (m_busy) begin
        if (mem_ready) begin
          m_fd   = m_we && (int'(m_addr) == FP - 1);
          m_busy = 0;
        end
      end else if (rg) begin
        m_busy = 1; m_we = 0; m_addr = rd_addr; m_wdata = '0;
        m_starve = wr_valid ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
      end else if (wg) begin
        m_busy = 1; m_we = 1; m_wdata = wr_data;
        m_addr = wr_sof ? '0 : AW'(m_wptr);
        m_wptr = wr_sof ? (1 % FP) : ((m_wptr + 1) % FP);
        m_starve = 0;
      end else begin
        m_starve = 0;
      end
      m_prev_rd  = mem_rdata;
      m_prev_rdv = mem_rdata_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_wr(input logic [7:0] d, input logic s);
    bit acc = 0;
    wr_valid = 1'b1; wr_data = d; wr_sof = s;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = wr_ready;
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0; wr_sof = 1'b0;
    chk("wr_accept", acc, 1);
  endtask

  // ---------------- directed expectation tables ----------------
  int    exp_a1[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
  int    exp_a2[9] = '{0, 1, 2, 0, 1, 2, 3, 4, 5};
  string order = "RRRRWRRRRW";

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int cnt;
    reset = 1'b1;
    wr_valid = 0; wr_data = 0; wr_sof = 0; rd_valid = 0; rd_addr = '0;
    mem_ready = 0; mem_rdata = 0; mem_rdata_valid = 0;
    #1 reset = 1'b0;

    // 1: reset held with random inputs, then release with nothing valid.
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'($urandom_range(0, 1)); wr_data = 8'($urandom_range(0, 255));
      wr_sof = 1'($urandom_range(0, 1)); rd_valid = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 1000)); mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom_range(0, 255)); mem_rdata_valid = 1'($urandom_range(0, 1));
      step(1);
    end
    wr_valid = 0; wr_sof = 0; rd_valid = 0; mem_ready = 0; mem_rdata = 0; mem_rdata_valid = 0;
    step(1);
    reset = 1'b1;
    clear_logs();
    step(4);
    chk("t1_no_transfer", log_we.size(), 0);

    // 2: writer only, back-to-back pixels.
    clear_logs();
    mem_ready = 1;
    send_wr(8'h11, 1'b1);
    send_wr(8'h22, 1'b0);
    send_wr(8'h33, 1'b0);
    send_wr(8'h44, 1'b0);
    step(3);
    exp_q.push_back(32'h11); exp_q.push_back(32'h22);
    exp_q.push_back(32'h33); exp_q.push_back(32'h44);
    chk("t2_count", log_we.size(), 4);
    for (int i = 0; i < log_we.size() && i < 4; i++) begin
      chk("t2_we", log_we[i], 1);
      chk("t2_addr", log_addr[i], i);
      chk("t2_data", log_data[i], exp_q[i]);
      if (i > 0) chk("t2_spacing", log_cyc[i] - log_cyc[i-1], 2);
    end

    // 3: write stalled by mem_ready=0 for 5 cycles; reader waits meanwhile.
    clear_logs();
    mem_ready = 0;
    wr_valid = 1; wr_data = 8'h5A; wr_sof = 0;
    @(negedge clk);
    chk("t3_grant", wr_ready, 1);
    @(posedge clk); #1;
    wr_valid = 0; rd_valid = 1; rd_addr = AW'(5);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt += int'(mem_valid);
      @(posedge clk); #1;
    end
    mem_ready = 1;
    @(negedge clk);
    cnt += int'(mem_valid);
    @(posedge clk); #1;
    rd_valid = 0;
    step(2);
    chk("t3_hold_cycles", cnt, 6);
    chk("t3_count", log_we.size(), 1);
    if (log_we.size() > 0) begin
      chk("t3_addr", log_addr[0], 4);
      chk("t3_data", log_data[0], 32'h5A);
    end

    // 4: both requesters saturate the port; starvation guard interleaves.
    clear_logs();
    step(2);
    rd_valid = 1; wr_valid = 1; wr_sof = 0;
    for (int i = 0; i < 40 && log_we.size() < 10; i++) begin
      rd_addr = AW'(100 + i);
      wr_data = 8'(i);
      step(1);
    end
    rd_valid = 0; wr_valid = 0;
    step(2);
    chk("t4_count", log_we.size(), 10);
    for (int i = 0; i < log_we.size() && i < 10; i++)
      chk("t4_order", log_we[i], order[i] == "W");

    // 5a: one full frame plus one pixel; frame_done after address 7.
    clear_logs();
    for (int i = 0; i < 9; i++) send_wr(8'(8'h80 + i), i == 0);
    step(3);
    chk("t5a_count", log_we.size(), 9);
    for (int i = 0; i < log_we.size() && i < 9; i++) begin
      chk("t5a_addr", log_addr[i], exp_a1[i]);
      chk("t5a_data", log_data[i], 32'h80 + i);
    end
    chk("t5a_fd_count", fd_cyc.size(), 1);
    if (fd_cyc.size() > 0 && log_cyc.size() > 7)
      chk("t5a_fd_timing", fd_cyc[0] - log_cyc[7], 1);

    // 5b: sof mid-frame restarts at 0, no frame_done.
    clear_logs();
    for (int i = 0; i < 9; i++) send_wr(8'(8'hC0 + i), (i == 0) || (i == 3));
    step(3);
    chk("t5b_count", log_we.size(), 9);
    for (int i = 0; i < log_we.size() && i < 9; i++)
      chk("t5b_addr", log_addr[i], exp_a2[i]);
    chk("t5b_fd_count", fd_cyc.size(), 0);

    // 6: read data returned while a write is stalled in issue.
    clear_logs();
    mem_ready = 0;
    send_wr(8'h77, 1'b0);
    mem_rdata = 8'hA5; mem_rdata_valid = 1;
    step(1);
    mem_rdata = 8'h3C; mem_rdata_valid = 0;
    @(negedge clk);
    chk("t6_rd_data", rd_data, 32'hA5);
    chk("t6_rd_valid", rd_data_valid, 1);
    chk("t6_still_issuing", mem_valid, 1);
    @(negedge clk);
    chk("t6_rd_valid_pulse", rd_data_valid, 0);
    @(posedge clk); #1;
    mem_ready = 1;
    step(3);
    chk("t6_count", log_we.size(), 1);

    // 7: reset during an in-flight request abandons it.
    clear_logs();
    mem_ready = 0;
    send_wr(8'h99, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("t7_abandon", mem_valid, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    mem_ready = 1;
    step(3);
    chk("t7_no_transfer", log_we.size(), 0);
    send_wr(8'h12, 1'b0);
    step(2);
    chk("t7_count", log_we.size(), 1);
    if (log_we.size() > 0) chk("t7_addr_after_reset", log_addr[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
